gated_clock_ctrl: RTL

//  Single-clock sequencer that drives the COND/COND_EN write side of a GatedClock primitive and reads back its

---
 rtl/gated_clock_ctrl_pkg.sv | 17 +
 rtl/gc_sat_counter.sv | 30 +++
 rtl/gated_clock_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gated_clock_ctrl_pkg.sv
// Shared types for the gated-clock sequencer.
// State encodings and counter width helper.
package gated_clock_ctrl_pkg;

  typedef enum logic [2:0] {
    GC_RUN       = 3'd0,
    GC_OFF_PEND  = 3'd1,
    GC_OFF       = 3'd2,
    GC_WAKE_PEND = 3'd3,
    GC_SETTLE    = 3'd4
  } gc_state_e;

  function automatic int gc_cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/gc_sat_counter.sv
// Saturating up-counter with clear and at-limit flag.
// Holds at LIMIT until cleared.
module gc_sat_counter
  import gated_clock_ctrl_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic at_lim
);

  localparam int W = gc_cnt_w(LIMIT);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  assign at_lim = (cnt == LIM);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en && !at_lim) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gated_clock_ctrl.sv
// Always-on sequencer driving the COND/COND_EN side of a GatedClock
// and tracking its registered COND_OUT for sleep, wake and settle.
module gated_clock_ctrl
  import gated_clock_ctrl_pkg::*;
#(
  parameter bit INIT         = 1'b1,
  parameter int IDLE_CYCLES  = 16,
  parameter int WAKE_CYCLES  = 4,
  parameter int PEND_TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AUTO_EN,
  input  logic        ACTIVITY,
  input  logic        SLEEP_REQ,
  input  logic        WAKE_REQ,
  output logic        COND,
  output logic        COND_EN,
  input  logic        COND_OUT,
  output logic        READY,
  output logic        SLEEPING,
  output logic        ERR,
  output logic [15:0] SLEEP_COUNT
);

  localparam gc_state_e RST_ST = INIT ? GC_RUN : GC_OFF;

  gc_state_e   state_q, state_d;
  logic        cond_q, cond_d;
  logic        cond_en_q, cond_en_d;
  logic        ready_q, ready_d;
  logic        slp_q, slp_d;
  logic        err_q, err_d;
  logic        wpend_q, wpend_d;
  logic        mis_q, mis_d;
  logic [15:0] sleep_cnt_q, sleep_cnt_d;
  logic        idle_go, pend_in, setl_in, wake_in, mism;
  logic        idle_at, pend_at, setl_at;

  assign idle_go = (state_q == GC_RUN) && AUTO_EN && !ACTIVITY;
  assign pend_in = (state_q == GC_OFF_PEND)
                || (state_q == GC_WAKE_PEND);
  assign setl_in = (state_q == GC_SETTLE);
  assign wake_in = WAKE_REQ || ACTIVITY;

  gc_sat_counter #(.LIMIT(IDLE_CYCLES)) u_idle (
    .CLK(CLK), .RST(RST),
    .clr(!idle_go), .en(idle_go),
    .at_lim(idle_at)
  );

  // Last waiting cycle is the timeout cycle
  gc_sat_counter #(.LIMIT(PEND_TIMEOUT - 1)) u_pend (
    .CLK(CLK), .RST(RST),
    .clr(!pend_in), .en(pend_in),
    .at_lim(pend_at)
  );

  gc_sat_counter #(.LIMIT(WAKE_CYCLES - 1)) u_setl (
    .CLK(CLK), .RST(RST),
    .clr(!setl_in), .en(setl_in),
    .at_lim(setl_at)
  );

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    cond_en_d   = 1'b0;
    ready_d     = ready_q;
    slp_d       = slp_q;
    err_d       = err_q;
    wpend_d     = wpend_q;
    mis_d       = 1'b0;
    sleep_cnt_d = sleep_cnt_q;
    mism        = 1'b0;
    unique case (state_q)
      GC_RUN: begin
        mism = !COND_OUT;
        if ((SLEEP_REQ || idle_at) && !wake_in) begin
          state_d   = GC_OFF_PEND;
          cond_d    = 1'b0;
          cond_en_d = 1'b1;
          ready_d   = 1'b0;
        end
      end
      GC_OFF_PEND: begin
        if (wake_in) wpend_d = 1'b1;
        if (!COND_OUT) begin
          state_d     = GC_OFF;
          slp_d       = 1'b1;
          sleep_cnt_d = sleep_cnt_q + 16'd1;
        end else if (pend_at) begin
          state_d = GC_OFF;
          err_d   = 1'b1;
        end
      end
      GC_OFF: begin
        mism = COND_OUT;
        if (wake_in || wpend_q) begin
          state_d   = GC_WAKE_PEND;
          cond_d    = 1'b1;
          cond_en_d = 1'b1;
          slp_d     = 1'b0;
          wpend_d   = 1'b0;
        end
      end
      GC_WAKE_PEND: begin
        if (COND_OUT) begin
          state_d = GC_SETTLE;
        end else if (pend_at) begin
          state_d = GC_SETTLE;
          err_d   = 1'b1;
        end
      end
      GC_SETTLE: begin
        if (setl_at) begin
          state_d = GC_RUN;
          ready_d = 1'b1;
        end
      end
      default: state_d = RST_ST;
    endcase
    // Second consecutive disagreement rewrites the gate
    if (mism && (state_d == state_q)) begin
      if (mis_q) begin
        cond_en_d = 1'b1;
        cond_d    = (state_q == GC_RUN);
      end else begin
        mis_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RST_ST;
      cond_q      <= INIT;
      cond_en_q   <= 1'b0;
      ready_q     <= INIT;
      slp_q       <= !INIT;
      err_q       <= 1'b0;
      wpend_q     <= 1'b0;
      mis_q       <= 1'b0;
      sleep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      cond_en_q   <= cond_en_d;
      ready_q     <= ready_d;
      slp_q       <= slp_d;
      err_q       <= err_d;
      wpend_q     <= wpend_d;
      mis_q       <= mis_d;
      sleep_cnt_q <= sleep_cnt_d;
    end
  end

  assign COND        = cond_q;
  assign COND_EN     = cond_en_q;
  assign READY       = ready_q;
  assign SLEEPING    = slp_q;
  assign ERR         = err_q;
  assign SLEEP_COUNT = sleep_cnt_q;

endmodule
